dsp_muladdsub_pipe: RTL and testbench
=====================================

// Module: dsp_muladdsub_pipe
// PURPOSE
//  Parametrised multiply-add/sub engine: z = (loadc ? c : z_fb) +/- (a*b) + cin.
//  Generalises the fixed 18x18 MULTADDSUB DUT with configurable widths, six
//  optional register stages, an accumulate (z feedback) mode and a sticky overflow flag.
//  Serves as the golden model and DUT wrapper on the Nexus DSP hardware-test benches.
// PARAMETERS
//  A_W       18  width of a
//  B_W       18  width of b
//  C_W       54  width of c
//  Z_W       54  width of z (must be >= A_W+B_W and >= C_W)
//  REG_IN    0   1 = register a,b (stage IN)
//  REG_C     0   1 = register c (stage C)
//  REG_CTRL  0   1 = register is_signed, addsub, loadc (stage CTRL)
//  REG_CIN   1   1 = register cin (stage CIN)
//  REG_PIPE  0   1 = register the product (stage PIPE)
//  REG_OUT   0   1 = register z (stage OUT); must be 1 if loadc is ever 0
// PORTS
//  clk        in   1    clock, all flops rising edge
//  rst        in   1    async active-high reset, clears every flop
//  strobe     in   1    qualifies all ce_* and srst_* below
//  ce_in      in   1    stage IN enable
//  srst_in    in   1    stage IN sync reset
//  ce_c, srst_c, ce_ctrl, srst_ctrl, ce_cin, srst_cin, ce_pipe, srst_pipe,
//  ce_out, srst_out  in 1 each: same meaning for the named stage
//  is_signed  in   1    1 = a,b,c two's complement; 0 = unsigned
//  addsub     in   1    0 = add product, 1 = subtract product
//  loadc      in   1    1 = addend is c; 0 = addend is registered z (accumulate)
//  cin        in   1    carry-in, always added (+1)
//  a          in   A_W  multiplicand
//  b          in   B_W  multiplier
//  c          in   C_W  addend
//  z          out  Z_W  result, modulo 2^Z_W
//  ovf        out  1    sticky overflow flag
// BEHAVIOUR
//  - Effective stage ce = ce_x & strobe; effective sync reset = srst_x & strobe.
//    Sync reset beats ce. strobe=0: every stage register holds.
//  - Stage with REG_x=0 is a wire: its ce/srst are ignored.
//  - Datapath: a,b -> [IN] -> mult -> [PIPE] -> adder -> [OUT] -> z.
//    c -> [C] -> adder; cin -> [CIN] -> adder; ctrl -> [CTRL] -> mult sign + adder.
//  - No automatic alignment: side-stage registers feed the adder directly.
//    Latency a,b->z = REG_IN+REG_PIPE+REG_OUT. Stimulus must skew c/cin/ctrl to match.
//  - is_signed=1: a, b and c are sign-extended to Z_W+1 bits; otherwise zero-extended.
//    The product is full width A_W+B_W. The sum is formed in Z_W+1 bits.
//  - ovf sets when the true sum is outside the z range:
//    signed [-2^(Z_W-1), 2^(Z_W-1)-1]; unsigned [0, 2^Z_W-1].
//    ovf is always a flop; it updates on ce_out & strobe (every cycle if REG_OUT=0).
//    ovf is cleared only by rst or srst_out & strobe.
//  - Accumulate: loadc=0 selects the OUT-register value as addend.
//    REG_OUT=0 with loadc=0 is illegal (assertion; z undefined).
//  - Reset values: every stage register 0, z=0, ovf=0.
//    Async rst mid-accumulate returns z to 0 immediately, not at the next edge.
//  - Simultaneous srst_out & ce_out & strobe: z=0, ovf=0 that cycle.
//    Accumulation then restarts from 0 if loadc=0.
// STRUCTURE
//  - Package dsp_muladd_pkg holds:
//    function lat(REG_IN,REG_PIPE,REG_OUT) and stage-index localparams.
//  - One sub-module dsp_stage_reg #(W, EN): optional register with ce/srst/async rst.
//    It is instantiated once per stage. The adder and overflow logic stay in the top.
// TESTING
//  1 Defaults, signed, a=-3 b=5 c=100 addsub=0 cin=1, strobe=ce_cin=1
//    -> z=86 one cycle after cin is registered; z=85 while cin reg=0.
//  2 Unsigned a=1000 b=1000 c=2000000 addsub=1 cin=0 -> z=1000000, ovf=0.
//  3 REG_OUT=1, cycle0 loadc=1 c=7 a=2 b=3; then loadc=0
//    -> z=13,19,25 on successive edges.
//    Then srst_out&strobe -> z=0, and the next edge gives z=6.
//  4 strobe=0 with all ce=1 and srst=1 for 5 cycles
//    -> all registers hold, z unchanged.
//    srst_pipe=ce_pipe=strobe=1 -> product reg=0 (reset wins).
//  5 A_W=B_W=4 Z_W=C_W=8 signed REG_OUT=1, c=127 a=1 b=1
//    -> z=-128 (0x80), ovf=1, ovf stays 1 with later in-range sums.
//    Async rst -> z=0, ovf=0 without a clock edge.
//  6 All REG_*=1, randomised a,b,c,ctrl with correct skew
//    -> z matches the reference model at latency 3, 1000 vectors, both signedness modes.

Source files
------------

// File: rtl/dsp_muladd_pkg.sv
// Shared constants for the multiply-add/sub pipeline: stage indices into the
// per-stage enable/reset vectors, control-word bit positions, and the a,b->z
// latency helper used by anything that has to skew stimulus against the pipe.
package dsp_muladd_pkg;

   localparam int STG_IN   = 0;
   localparam int STG_C    = 1;
   localparam int STG_CTRL = 2;
   localparam int STG_CIN  = 3;
   localparam int STG_PIPE = 4;
   localparam int STG_OUT  = 5;
   localparam int N_STG    = 6;

   localparam int CTRL_LOADC  = 0;
   localparam int CTRL_ADDSUB = 1;
   localparam int CTRL_SIGNED = 2;
   localparam int CTRL_W      = 3;

   function automatic int lat(input int reg_in, input int reg_pipe, input int reg_out);
      return reg_in + reg_pipe + reg_out;
   endfunction

endpackage

// File: rtl/dsp_stage_reg.sv
// Optional pipeline register. With EN=0 it collapses to a wire and the
// enable/reset inputs are ignored; with EN=1 it is a flop with async reset,
// a synchronous reset that overrides the clock enable, and a clock enable.
module dsp_stage_reg #(
   parameter int W  = 1,
   parameter int EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         srst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (EN != 0) begin : g_reg
         // stage register: async clear, sync clear beats enable
         always_ff @(posedge clk or posedge rst) begin
            if (rst)       q <= '0;
            else if (srst) q <= '0;
            else if (ce)   q <= d;
         end
      end else begin : g_wire
         logic unused_ctl;
         assign unused_ctl = &{1'b0, clk, rst, ce, srst};
         assign q = d;
      end
   endgenerate

endmodule

// File: rtl/dsp_muladdsub_pipe.sv
// Parametrised multiply-add/sub engine: z = (loadc ? c : z_fb) +/- a*b + cin.
// Six optional stage registers, accumulate through the OUT register, and a
// sticky overflow flag. Side stages (c, cin, ctrl) are not auto-aligned to
// the a,b path; the caller skews them.
module dsp_muladdsub_pipe
   import dsp_muladd_pkg::*;
#(
   parameter int A_W      = 18,
   parameter int B_W      = 18,
   parameter int C_W      = 54,
   parameter int Z_W      = 54,
   parameter int REG_IN   = 0,
   parameter int REG_C    = 0,
   parameter int REG_CTRL = 0,
   parameter int REG_CIN  = 1,
   parameter int REG_PIPE = 0,
   parameter int REG_OUT  = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           strobe,
   input  logic           ce_in,
   input  logic           srst_in,
   input  logic           ce_c,
   input  logic           srst_c,
   input  logic           ce_ctrl,
   input  logic           srst_ctrl,
   input  logic           ce_cin,
   input  logic           srst_cin,
   input  logic           ce_pipe,
   input  logic           srst_pipe,
   input  logic           ce_out,
   input  logic           srst_out,
   input  logic           is_signed,
   input  logic           addsub,
   input  logic           loadc,
   input  logic           cin,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   input  logic [C_W-1:0] c,
   output logic [Z_W-1:0] z,
   output logic           ovf
);

   localparam int P_W = A_W + B_W;
   // one guard bit beyond Z_W+1 keeps the overflow compare exact at the extreme corners
   localparam int S_W = Z_W + 2;

   logic [N_STG-1:0]  ce_v, srst_v;
   logic [P_W-1:0]    ab_q, a_x, b_x, prod, prod_q;
   logic [A_W-1:0]    a_q;
   logic [B_W-1:0]    b_q;
   logic [C_W-1:0]    c_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic              cin_q, sgn, sub_q, loadc_q;
   logic [Z_W-1:0]    z_q, z_fb;
   logic [S_W-1:0]    p_x, c_x, zf_x, add_x, cin_x, sum;
   logic              ovf_now, ovf_upd;

   assign ce_v[STG_IN]     = ce_in   & strobe;
   assign ce_v[STG_C]      = ce_c    & strobe;
   assign ce_v[STG_CTRL]   = ce_ctrl & strobe;
   assign ce_v[STG_CIN]    = ce_cin  & strobe;
   assign ce_v[STG_PIPE]   = ce_pipe & strobe;
   assign ce_v[STG_OUT]    = ce_out  & strobe;
   assign srst_v[STG_IN]   = srst_in   & strobe;
   assign srst_v[STG_C]    = srst_c    & strobe;
   assign srst_v[STG_CTRL] = srst_ctrl & strobe;
   assign srst_v[STG_CIN]  = srst_cin  & strobe;
   assign srst_v[STG_PIPE] = srst_pipe & strobe;
   assign srst_v[STG_OUT]  = srst_out  & strobe;

   assign ctrl_d[CTRL_SIGNED] = is_signed;
   assign ctrl_d[CTRL_ADDSUB] = addsub;
   assign ctrl_d[CTRL_LOADC]  = loadc;

   dsp_stage_reg #(.W(P_W), .EN(REG_IN)) u_in (
      .clk(clk), .rst(rst), .ce(ce_v[STG_IN]), .srst(srst_v[STG_IN]), .d({a, b}), .q(ab_q));
   dsp_stage_reg #(.W(C_W), .EN(REG_C)) u_c (
      .clk(clk), .rst(rst), .ce(ce_v[STG_C]), .srst(srst_v[STG_C]), .d(c), .q(c_q));
   dsp_stage_reg #(.W(CTRL_W), .EN(REG_CTRL)) u_ctrl (
      .clk(clk), .rst(rst), .ce(ce_v[STG_CTRL]), .srst(srst_v[STG_CTRL]), .d(ctrl_d), .q(ctrl_q));
   dsp_stage_reg #(.W(1), .EN(REG_CIN)) u_cin (
      .clk(clk), .rst(rst), .ce(ce_v[STG_CIN]), .srst(srst_v[STG_CIN]), .d(cin), .q(cin_q));
   dsp_stage_reg #(.W(P_W), .EN(REG_PIPE)) u_pipe (
      .clk(clk), .rst(rst), .ce(ce_v[STG_PIPE]), .srst(srst_v[STG_PIPE]), .d(prod), .q(prod_q));
   dsp_stage_reg #(.W(Z_W), .EN(REG_OUT)) u_out (
      .clk(clk), .rst(rst), .ce(ce_v[STG_OUT]), .srst(srst_v[STG_OUT]), .d(sum[Z_W-1:0]), .q(z_q));

   assign a_q     = ab_q[P_W-1:B_W];
   assign b_q     = ab_q[B_W-1:0];
   assign sgn     = ctrl_q[CTRL_SIGNED];
   assign sub_q   = ctrl_q[CTRL_ADDSUB];
   assign loadc_q = ctrl_q[CTRL_LOADC];

   // full-width product; extending both operands to P_W makes one multiplier serve both modes
   always_comb begin
      a_x  = {{B_W{a_q[A_W-1] & sgn}}, a_q};
      b_x  = {{A_W{b_q[B_W-1] & sgn}}, b_q};
      prod = a_x * b_x;
   end

   // feedback only exists when the OUT register does; otherwise it would be a combinational loop
   generate
      if (REG_OUT != 0) begin : g_fb
         assign z_fb = z_q;
      end else begin : g_nofb
         assign z_fb = '0;
      end
   endgenerate

   // extend every operand, select the addend, then add or subtract the product plus carry-in
   always_comb begin
      p_x   = {{(S_W-P_W){prod_q[P_W-1] & sgn}}, prod_q};
      c_x   = {{(S_W-C_W){c_q[C_W-1] & sgn}}, c_q};
      zf_x  = {{(S_W-Z_W){z_fb[Z_W-1] & sgn}}, z_fb};
      cin_x = {{(S_W-1){1'b0}}, cin_q};
      add_x = loadc_q ? c_x : zf_x;
      sum   = sub_q ? (add_x - p_x + cin_x) : (add_x + p_x + cin_x);
   end

   // signed: top bits must all match the z sign bit; unsigned: nothing above bit Z_W-1
   always_comb begin
      ovf_now = 1'b0;
      if (sgn) ovf_now = !((&sum[S_W-1:Z_W-1]) || (~|sum[S_W-1:Z_W-1]));
      else     ovf_now = |sum[S_W-1:Z_W];
   end

   assign ovf_upd = (REG_OUT != 0) ? ce_v[STG_OUT] : 1'b1;

   // sticky overflow, cleared only by reset or the OUT-stage sync reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  ovf <= 1'b0;
      else if (srst_v[STG_OUT]) ovf <= 1'b0;
      else if (ovf_upd)         ovf <= ovf | ovf_now;
   end

   assign z = z_q;

   a_acc_needs_out: assert property (@(posedge clk) disable iff (rst) (REG_OUT != 0) || loadc_q);

endmodule

// File: tb/tb_dsp_muladdsub_pipe.sv
module tb_dsp_muladdsub_pipe;
   import dsp_muladd_pkg::*;

   localparam int LAT_ALL = lat(1, 1, 1);
   localparam int NV = 500;

   logic clk, rst, strobe, is_signed, addsub, cin, loadc_acc, loadc_all;
   logic [N_STG-1:0] ce, srst;
   logic [17:0] a, b;
   logic [53:0] c;
   logic [3:0]  a4, b4;
   logic [7:0]  c8;
   logic [53:0] z_def, z_acc, z_all;
   logic [7:0]  z_sm;
   logic ovf_def, ovf_acc, ovf_all, ovf_sm;
   int total, bad;

   logic [17:0] va [NV];
   logic [17:0] vb [NV];
   logic [53:0] vc [NV];
   logic        vs [NV];
   logic        vn [NV];

   dsp_muladdsub_pipe u_def (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce_in(ce[STG_IN]), .srst_in(srst[STG_IN]), .ce_c(ce[STG_C]), .srst_c(srst[STG_C]),
      .ce_ctrl(ce[STG_CTRL]), .srst_ctrl(srst[STG_CTRL]), .ce_cin(ce[STG_CIN]), .srst_cin(srst[STG_CIN]),
      .ce_pipe(ce[STG_PIPE]), .srst_pipe(srst[STG_PIPE]), .ce_out(ce[STG_OUT]), .srst_out(srst[STG_OUT]),
      .is_signed(is_signed), .addsub(addsub), .loadc(1'b1), .cin(cin),
      .a(a), .b(b), .c(c), .z(z_def), .ovf(ovf_def));

   dsp_muladdsub_pipe #(.REG_OUT(1)) u_acc (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce_in(ce[STG_IN]), .srst_in(srst[STG_IN]), .ce_c(ce[STG_C]), .srst_c(srst[STG_C]),
      .ce_ctrl(ce[STG_CTRL]), .srst_ctrl(srst[STG_CTRL]), .ce_cin(ce[STG_CIN]), .srst_cin(srst[STG_CIN]),
      .ce_pipe(ce[STG_PIPE]), .srst_pipe(srst[STG_PIPE]), .ce_out(ce[STG_OUT]), .srst_out(srst[STG_OUT]),
      .is_signed(is_signed), .addsub(addsub), .loadc(loadc_acc), .cin(cin),
      .a(a), .b(b), .c(c), .z(z_acc), .ovf(ovf_acc));

   dsp_muladdsub_pipe #(.REG_IN(1), .REG_C(1), .REG_CTRL(1), .REG_CIN(1), .REG_PIPE(1), .REG_OUT(1)) u_all (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce_in(ce[STG_IN]), .srst_in(srst[STG_IN]), .ce_c(ce[STG_C]), .srst_c(srst[STG_C]),
      .ce_ctrl(ce[STG_CTRL]), .srst_ctrl(srst[STG_CTRL]), .ce_cin(ce[STG_CIN]), .srst_cin(srst[STG_CIN]),
      .ce_pipe(ce[STG_PIPE]), .srst_pipe(srst[STG_PIPE]), .ce_out(ce[STG_OUT]), .srst_out(srst[STG_OUT]),
      .is_signed(is_signed), .addsub(addsub), .loadc(loadc_all), .cin(cin),
      .a(a), .b(b), .c(c), .z(z_all), .ovf(ovf_all));

   dsp_muladdsub_pipe #(.A_W(4), .B_W(4), .C_W(8), .Z_W(8), .REG_OUT(1)) u_sm (
      .clk(clk), .rst(rst), .strobe(strobe),
      .ce_in(ce[STG_IN]), .srst_in(srst[STG_IN]), .ce_c(ce[STG_C]), .srst_c(srst[STG_C]),
      .ce_ctrl(ce[STG_CTRL]), .srst_ctrl(srst[STG_CTRL]), .ce_cin(ce[STG_CIN]), .srst_cin(srst[STG_CIN]),
      .ce_pipe(ce[STG_PIPE]), .srst_pipe(srst[STG_PIPE]), .ce_out(ce[STG_OUT]), .srst_out(srst[STG_OUT]),
      .is_signed(is_signed), .addsub(addsub), .loadc(1'b1), .cin(cin),
      .a(a4), .b(b4), .c(c8), .z(z_sm), .ovf(ovf_sm));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      strobe = 1'b0; ce = '0; srst = '0;
      is_signed = 1'b0; addsub = 1'b0; cin = 1'b0;
      loadc_acc = 1'b1; loadc_all = 1'b1;
      a = '0; b = '0; c = '0; a4 = '0; b4 = '0; c8 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      #2;
      total++; if (z_def !== 54'd0) begin bad++; $display("FAIL reset_z_def got=%0d exp=0", z_def); end
      total++; if (z_acc !== 54'd0) begin bad++; $display("FAIL reset_z_acc got=%0d exp=0", z_acc); end
      total++; if (z_all !== 54'd0) begin bad++; $display("FAIL reset_z_all got=%0d exp=0", z_all); end
      total++; if (z_sm !== 8'd0) begin bad++; $display("FAIL reset_z_sm got=%0d exp=0", z_sm); end
      total++; if ({ovf_def, ovf_acc, ovf_all, ovf_sm} !== 4'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0000", {ovf_def, ovf_acc, ovf_all, ovf_sm}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_signed_default();
      set_idle(); do_reset();
      strobe = 1'b1; ce = '1; is_signed = 1'b1; addsub = 1'b0; cin = 1'b1;
      a = 18'h3FFFD; b = 18'd5; c = 54'd100;
      #1;
      total++; if (z_def !== 54'd85) begin bad++; $display("FAIL def_cin0 got=%0d exp=85", z_def); end
      tick();
      total++; if (z_def !== 54'd86) begin bad++; $display("FAIL def_cin1 got=%0d exp=86", z_def); end
      total++; if (ovf_def !== 1'b0) begin bad++; $display("FAIL def_ovf got=%b exp=0", ovf_def); end
      addsub = 1'b1;
      #1;
      total++; if (z_def !== 54'd116) begin bad++; $display("FAIL def_sub got=%0d exp=116", z_def); end
   endtask

   task automatic test_unsigned_default();
      is_signed = 1'b0; cin = 1'b0; addsub = 1'b1;
      a = 18'd1000; b = 18'd1000; c = 54'd2000000;
      tick();
      total++; if (z_def !== 54'd1000000) begin bad++; $display("FAIL uns_sub got=%0d exp=1000000", z_def); end
      total++; if (ovf_def !== 1'b0) begin bad++; $display("FAIL uns_ovf0 got=%b exp=0", ovf_def); end
      a = 18'd1; b = 18'd1; c = 54'd0;
      tick();
      total++; if (z_def !== {54{1'b1}}) begin bad++; $display("FAIL uns_under_z got=%h exp=3fffffffffffff", z_def); end
      total++; if (ovf_def !== 1'b1) begin bad++; $display("FAIL uns_under_ovf got=%b exp=1", ovf_def); end
      c = 54'd5; srst[STG_OUT] = 1'b1;
      tick();
      total++; if (ovf_def !== 1'b0) begin bad++; $display("FAIL uns_srst_ovf got=%b exp=0", ovf_def); end
      srst = '0;
   endtask

   task automatic test_accumulate();
      set_idle(); do_reset();
      strobe = 1'b1; ce = '1; is_signed = 1'b1; cin = 1'b0;
      loadc_acc = 1'b1; c = 54'd7; a = 18'd2; b = 18'd3;
      tick();
      total++; if (z_acc !== 54'd13) begin bad++; $display("FAIL acc_load got=%0d exp=13", z_acc); end
      loadc_acc = 1'b0;
      tick();
      total++; if (z_acc !== 54'd19) begin bad++; $display("FAIL acc_1 got=%0d exp=19", z_acc); end
      tick();
      total++; if (z_acc !== 54'd25) begin bad++; $display("FAIL acc_2 got=%0d exp=25", z_acc); end
      srst[STG_OUT] = 1'b1;
      tick();
      total++; if (z_acc !== 54'd0) begin bad++; $display("FAIL acc_srst got=%0d exp=0", z_acc); end
      srst = '0;
      tick();
      total++; if (z_acc !== 54'd6) begin bad++; $display("FAIL acc_restart got=%0d exp=6", z_acc); end
      total++; if (ovf_acc !== 1'b0) begin bad++; $display("FAIL acc_ovf got=%b exp=0", ovf_acc); end
   endtask

   task automatic test_strobe_hold();
      set_idle(); do_reset();
      strobe = 1'b1; ce = '1; is_signed = 1'b1; loadc_all = 1'b1;
      a = 18'd5; b = 18'd6; c = 54'd10;
      repeat (4) tick();
      total++; if (z_all !== 54'd40) begin bad++; $display("FAIL hold_fill got=%0d exp=40", z_all); end
      strobe = 1'b0; srst = '1; a = 18'd9; b = 18'd9; c = 54'd99; addsub = 1'b1;
      repeat (5) tick();
      total++; if (z_all !== 54'd40) begin bad++; $display("FAIL hold_z got=%0d exp=40", z_all); end
      total++; if (ovf_all !== 1'b0) begin bad++; $display("FAIL hold_ovf got=%b exp=0", ovf_all); end
      strobe = 1'b1; srst = '0; srst[STG_PIPE] = 1'b1; addsub = 1'b0;
      a = 18'd5; b = 18'd6; c = 54'd10;
      tick();
      total++; if (z_all !== 54'd40) begin bad++; $display("FAIL pipe_srst_1 got=%0d exp=40", z_all); end
      tick();
      total++; if (z_all !== 54'd10) begin bad++; $display("FAIL pipe_srst_2 got=%0d exp=10", z_all); end
      srst = '0;
   endtask

   task automatic test_small_overflow();
      set_idle(); do_reset();
      strobe = 1'b1; ce = '1; is_signed = 1'b1; cin = 1'b0;
      c8 = 8'd127; a4 = 4'd1; b4 = 4'd1;
      tick();
      total++; if (z_sm !== 8'h80) begin bad++; $display("FAIL sm_wrap_z got=%h exp=80", z_sm); end
      total++; if (ovf_sm !== 1'b1) begin bad++; $display("FAIL sm_wrap_ovf got=%b exp=1", ovf_sm); end
      c8 = 8'd1;
      tick();
      total++; if (z_sm !== 8'd2) begin bad++; $display("FAIL sm_inrange_z got=%0d exp=2", z_sm); end
      total++; if (ovf_sm !== 1'b1) begin bad++; $display("FAIL sm_sticky got=%b exp=1", ovf_sm); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (z_sm !== 8'd0) begin bad++; $display("FAIL sm_arst_z got=%0d exp=0", z_sm); end
      total++; if (ovf_sm !== 1'b0) begin bad++; $display("FAIL sm_arst_ovf got=%b exp=0", ovf_sm); end
      rst = 1'b0;
      c8 = 8'd126;
      tick();
      total++; if (z_sm !== 8'd127) begin bad++; $display("FAIL sm_max_z got=%0d exp=127", z_sm); end
      total++; if (ovf_sm !== 1'b0) begin bad++; $display("FAIL sm_max_ovf got=%b exp=0", ovf_sm); end
      c8 = 8'h80; addsub = 1'b1;
      tick();
      total++; if (z_sm !== 8'h7F) begin bad++; $display("FAIL sm_neg_z got=%h exp=7f", z_sm); end
      total++; if (ovf_sm !== 1'b1) begin bad++; $display("FAIL sm_neg_ovf got=%b exp=1", ovf_sm); end
   endtask

   task automatic test_back_to_back();
      longint sa, sb, sc, cn, s;
      logic [53:0] ez;
      logic eovf, now;
      int j;
      for (int m = 0; m < 2; m++) begin
         set_idle(); do_reset();
         strobe = 1'b1; ce = '1; loadc_all = 1'b1; is_signed = (m == 0);
         eovf = 1'b0;
         for (int i = 0; i < NV; i++) begin
            va[i] = 18'($urandom());
            vb[i] = 18'($urandom());
            vc[i] = 54'({$urandom(), $urandom()});
            vs[i] = 1'($urandom());
            vn[i] = 1'($urandom());
         end
         for (int k = 0; k < NV + LAT_ALL - 1; k++) begin
            if (k < NV) begin a = va[k]; b = vb[k]; end
            else begin a = '0; b = '0; end
            if (k >= 1 && k - 1 < NV) begin c = vc[k-1]; addsub = vs[k-1]; cin = vn[k-1]; end
            else begin c = '0; addsub = 1'b0; cin = 1'b0; end
            tick();
            if (k >= LAT_ALL - 1) begin
               j = k - (LAT_ALL - 1);
               if (m == 0) begin
                  sa = longint'($signed(va[j])); sb = longint'($signed(vb[j])); sc = longint'($signed(vc[j]));
               end else begin
                  sa = longint'(va[j]); sb = longint'(vb[j]); sc = longint'(vc[j]);
               end
               cn = vn[j] ? 1 : 0;
               s = vs[j] ? (sc - sa * sb + cn) : (sc + sa * sb + cn);
               ez = s[53:0];
               if (m == 0) now = (s < -(longint'(1) <<< 53)) || (s > (longint'(1) <<< 53) - 1);
               else        now = (s < 0) || (s > (longint'(1) <<< 54) - 1);
               eovf = eovf | now;
               total++; if (z_all !== ez) begin bad++; $display("FAIL rnd_z mode=%0d j=%0d got=%h exp=%h", m, j, z_all, ez); end
               total++; if (ovf_all !== eovf) begin bad++; $display("FAIL rnd_ovf mode=%0d j=%0d got=%b exp=%b", m, j, ovf_all, eovf); end
            end
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1;
      set_idle();
      test_reset();
      test_signed_default();
      test_unsigned_default();
      test_accumulate();
      test_strobe_hold();
      test_small_overflow();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
